// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the chirp SPI arbiter and the VCO/DAC word sequencers:
// FSM encoding, device selects and the fixed per-device transfer settings.
package spi_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_SETTLE
    } arb_state_t;

    localparam logic        DEV_VCO      = 1'b1;
    localparam logic        DEV_DAC      = 1'b0;
    localparam logic [5:0]  VCO_NUM_BITS = 6'd32;
    localparam logic [5:0]  DAC_NUM_BITS = 6'd24;
    localparam logic [31:0] VCO_SCLK_DIV = 32'd4;

    localparam logic [1:0]  GRANT_NONE   = 2'b00;
    localparam logic [1:0]  GRANT_VCO    = 2'b10;
    localparam logic [1:0]  GRANT_DAC    = 2'b01;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_settle_timer.sv
// One-shot VCO lock hold-off timer: i_load starts a count 0..SETTLE_CYCLES-1,
// o_done is high in the final counted cycle.
module spi_settle_timer
    import spi_bus_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 12000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_load,
    output logic o_done
);

    localparam int unsigned   CNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_running;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (i_load) begin
            r_count   <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (r_count == LAST) begin
                r_running <= 1'b0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_done = r_running && (r_count == LAST);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Arbitrates the shared chirp_spi_core between the VCO programmer and the DAC
// chirp generator, with VCO priority, a VCO burst cap and post-VCO lock settling.
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 12000,
    parameter int unsigned MAX_VCO_BURST = 8,
    parameter int unsigned BUSY_TIMEOUT  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vco_req,
    input  logic [31:0] vco_data,
    input  logic        vco_settle,
    output logic        vco_ack,
    input  logic        dac_req,
    input  logic [31:0] dac_data,
    input  logic [31:0] dac_sclk_divider,
    output logic        dac_ack,
    output logic        core_start_tr,
    output logic        core_device,
    output logic [5:0]  core_num_bits,
    output logic [31:0] core_sclk_divider,
    output logic [31:0] core_set_data,
    input  logic        core_ready,
    output logic [1:0]  grant,
    output logic        settling,
    output logic        xfer_err
);

    localparam int unsigned BURST_W = cnt_width(MAX_VCO_BURST + 1);
    localparam int unsigned BUSY_W  = cnt_width(BUSY_TIMEOUT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_VCO_BURST);
    localparam logic [BUSY_W-1:0]  BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);

    arb_state_t         r_state;
    logic [BURST_W-1:0] r_vco_burst;
    logic [BUSY_W-1:0]  r_busy_cnt;
    logic               r_settle_pend;
    logic [1:0]         r_grant;
    logic               r_core_start_tr;
    logic               r_core_device;
    logic [5:0]         r_core_num_bits;
    logic [31:0]        r_core_sclk_divider;
    logic [31:0]        r_core_set_data;
    logic               r_vco_ack;
    logic               r_dac_ack;
    logic               r_settling;
    logic               r_xfer_err;

    logic w_vco_win;
    logic w_dac_win;
    logic w_arb_ok;
    logic w_timeout;
    logic w_complete;
    logic w_settle_load;
    logic w_settle_done;

    // The ack cycle is skipped for arbitration: the requester only sees its ack
    // then, so a still-high req there is the word that just finished.
    assign w_arb_ok   = (r_state == ST_IDLE) && !(r_vco_ack || r_dac_ack);
    assign w_vco_win  = vco_req && (!dac_req || (r_vco_burst < BURST_MAX));
    assign w_dac_win  = dac_req && !w_vco_win;
    assign w_timeout  = (r_state == ST_WAIT_BUSY) && core_ready && (r_busy_cnt == BUSY_LAST);
    assign w_complete = w_timeout || ((r_state == ST_WAIT_DONE) && core_ready);
    assign w_settle_load = w_complete && r_settle_pend;

    spi_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_settle_load),
        .o_done (w_settle_done)
    );

    // NOTE: state and every output are flops in this one block, assigned with <=,
    // so grant, core fields and start pulse all change on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= ST_IDLE;
            r_vco_burst         <= '0;
            r_busy_cnt          <= '0;
            r_settle_pend       <= 1'b0;
            r_grant             <= GRANT_NONE;
            r_core_start_tr     <= 1'b0;
            r_core_device       <= 1'b0;
            r_core_num_bits     <= '0;
            r_core_sclk_divider <= '0;
            r_core_set_data     <= '0;
            r_vco_ack           <= 1'b0;
            r_dac_ack           <= 1'b0;
            r_settling          <= 1'b0;
            r_xfer_err          <= 1'b0;
        end else begin
            r_core_start_tr <= 1'b0;
            r_vco_ack       <= 1'b0;
            r_dac_ack       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!vco_req) begin
                        r_vco_burst <= '0;
                    end
                    if (w_arb_ok && w_vco_win) begin
                        r_grant             <= GRANT_VCO;
                        r_core_device       <= DEV_VCO;
                        r_core_num_bits     <= VCO_NUM_BITS;
                        r_core_sclk_divider <= VCO_SCLK_DIV;
                        r_core_set_data     <= vco_data;
                        r_settle_pend       <= vco_settle;
                        r_core_start_tr     <= 1'b1;
                        r_state             <= ST_LAUNCH;
                        if (r_vco_burst != BURST_MAX) begin
                            r_vco_burst <= r_vco_burst + BURST_W'(1);
                        end
                    end else if (w_arb_ok && w_dac_win) begin
                        r_grant             <= GRANT_DAC;
                        r_core_device       <= DEV_DAC;
                        r_core_num_bits     <= DAC_NUM_BITS;
                        r_core_sclk_divider <= dac_sclk_divider;
                        r_core_set_data     <= dac_data;
                        r_settle_pend       <= 1'b0;
                        r_core_start_tr     <= 1'b1;
                        r_state             <= ST_LAUNCH;
                        r_vco_burst         <= '0;
                    end
                end
                ST_LAUNCH: begin
                    r_busy_cnt <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!core_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_timeout) begin
                        r_xfer_err <= 1'b1;
                    end else begin
                        r_busy_cnt <= r_busy_cnt + BUSY_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_SETTLE: begin
                    if (w_settle_done) begin
                        r_settling <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Normal completion and busy timeout share one ack path.
            if (w_complete) begin
                r_vco_ack  <= (r_grant == GRANT_VCO);
                r_dac_ack  <= (r_grant == GRANT_DAC);
                r_grant    <= GRANT_NONE;
                r_settling <= r_settle_pend;
                r_state    <= r_settle_pend ? ST_SETTLE : ST_IDLE;
            end
        end
    end

    assign vco_ack           = r_vco_ack;
    assign dac_ack           = r_dac_ack;
    assign core_start_tr     = r_core_start_tr;
    assign core_device       = r_core_device;
    assign core_num_bits     = r_core_num_bits;
    assign core_sclk_divider = r_core_sclk_divider;
    assign core_set_data     = r_core_set_data;
    assign grant             = r_grant;
    assign settling          = r_settling;
    assign xfer_err          = r_xfer_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: requester and core models, per-device
// expected-word scoreboard checked at each start pulse.
module tb_spi_bus_arbiter;

    localparam int unsigned SETTLE = 100;
    localparam int unsigned BURST  = 8;
    localparam int unsigned TOUT   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vco_req = 1'b0;
    logic [31:0] vco_data = '0;
    logic        vco_settle = 1'b0;
    logic        vco_ack;
    logic        dac_req = 1'b0;
    logic [31:0] dac_data = '0;
    logic [31:0] dac_sclk_divider = '0;
    logic        dac_ack;
    logic        core_start_tr;
    logic        core_device;
    logic [5:0]  core_num_bits;
    logic [31:0] core_sclk_divider;
    logic [31:0] core_set_data;
    logic        core_ready = 1'b1;
    logic [1:0]  grant;
    logic        settling;
    logic        xfer_err;

    always #5 clock = ~clock;

    spi_bus_arbiter #(
        .SETTLE_CYCLES (SETTLE),
        .MAX_VCO_BURST (BURST),
        .BUSY_TIMEOUT  (TOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .vco_req           (vco_req),
        .vco_data          (vco_data),
        .vco_settle        (vco_settle),
        .vco_ack           (vco_ack),
        .dac_req           (dac_req),
        .dac_data          (dac_data),
        .dac_sclk_divider  (dac_sclk_divider),
        .dac_ack           (dac_ack),
        .core_start_tr     (core_start_tr),
        .core_device       (core_device),
        .core_num_bits     (core_num_bits),
        .core_sclk_divider (core_sclk_divider),
        .core_set_data     (core_set_data),
        .core_ready        (core_ready),
        .grant             (grant),
        .settling          (settling),
        .xfer_err          (xfer_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] div;
    } exp_t;

    exp_t vco_q[$];
    exp_t dac_q[$];
    bit   start_log[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [31:0] div);
        exp_t e;
        e.data = d;
        e.div  = div;
        return e;
    endfunction

    // Core model: drops ready the cycle after a start, for busy_len cycles.
    int busy_len   = 40;
    bit core_stuck = 1'b0;
    int core_cnt   = 0;

    always @(posedge clock) begin
        if (reset) begin
            core_ready <= 1'b1;
            core_cnt   <= 0;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_ready <= 1'b1;
        end else if (core_start_tr && !core_stuck) begin
            core_ready <= 1'b0;
            core_cnt   <= busy_len;
        end
    end

    // Requesters keep req high across words while they still have words left.
    int vco_left = 0;
    int dac_left = 0;

    always @(negedge clock) begin
        if (!reset && vco_req && vco_ack) begin
            vco_left--;
            if (vco_left > 0) begin
                vco_data = vco_data + 32'd1;
                vco_q.push_back(mk(vco_data, 32'd4));
            end else begin
                vco_req = 1'b0;
            end
        end
        if (!reset && dac_req && dac_ack) begin
            dac_left--;
            if (dac_left > 0) begin
                dac_data = dac_data + 32'h100;
                dac_q.push_back(mk(dac_data, dac_sclk_divider));
            end else begin
                dac_req = 1'b0;
            end
        end
    end

    task automatic start_vco(input int n, input logic [31:0] d, input logic s);
        vco_left   = n;
        vco_data   = d;
        vco_settle = s;
        vco_q.push_back(mk(d, 32'd4));
        vco_req    = 1'b1;
    endtask

    task automatic start_dac(input int n, input logic [31:0] d);
        dac_left = n;
        dac_data = d;
        dac_q.push_back(mk(d, dac_sclk_divider));
        dac_req  = 1'b1;
    endtask

    // Monitor: pops the expected word of the started device and checks fields.
    int          starts = 0, vco_acks = 0, dac_acks = 0, settle_cnt = 0;
    int          start_cyc = 0, last_vco_ack_cyc = 0, dac_start_cyc = -1, err_cyc = -1;
    bit          dac_watch = 1'b0;
    logic [31:0] cur_exp_data = '0;

    always @(negedge clock) begin
        if (!reset) begin
            if (core_start_tr) begin
                exp_t e;
                starts++;
                start_cyc = cyc;
                start_log.push_back(core_device);
                if (core_device) begin
                    check("vco_start_expected", 64'(vco_q.size() > 0), 64'd1);
                    if (vco_q.size() > 0) begin
                        e = vco_q.pop_front();
                        cur_exp_data = e.data;
                        check("vco_num_bits", 64'(core_num_bits), 64'd32);
                        check("vco_divider", 64'(core_sclk_divider), 64'(e.div));
                        check("vco_data", 64'(core_set_data), 64'(e.data));
                        check("vco_grant", 64'(grant), 64'b10);
                    end
                end else begin
                    check("dac_start_expected", 64'(dac_q.size() > 0), 64'd1);
                    if (dac_q.size() > 0) begin
                        e = dac_q.pop_front();
                        cur_exp_data = e.data;
                        check("dac_num_bits", 64'(core_num_bits), 64'd24);
                        check("dac_divider", 64'(core_sclk_divider), 64'(e.div));
                        check("dac_data", 64'(core_set_data), 64'(e.data));
                        check("dac_grant", 64'(grant), 64'b01);
                    end
                    if (dac_watch && dac_start_cyc < 0) dac_start_cyc = cyc;
                end
            end
            if (vco_ack) begin
                vco_acks++;
                last_vco_ack_cyc = cyc;
                check("vco_ack_data_held", 64'(core_set_data), 64'(cur_exp_data));
                check("vco_ack_grant_clear", 64'(grant), 64'd0);
            end
            if (dac_ack) begin
                dac_acks++;
                check("dac_ack_data_held", 64'(core_set_data), 64'(cur_exp_data));
                check("dac_ack_grant_clear", 64'(grant), 64'd0);
            end
            if (settling) settle_cnt++;
            if (xfer_err && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic wait_quiet(input int budget, input string tag);
        int n = 0;
        while ((vco_req || dac_req) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_in_budget"}, 64'(n < budget), 64'd1);
        repeat (4) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_start"}, 64'(core_start_tr), 64'd0);
        check({tag, "_device"}, 64'(core_device), 64'd0);
        check({tag, "_num_bits"}, 64'(core_num_bits), 64'd0);
        check({tag, "_divider"}, 64'(core_sclk_divider), 64'd0);
        check({tag, "_data"}, 64'(core_set_data), 64'd0);
        check({tag, "_acks"}, 64'({vco_ack, dac_ack}), 64'd0);
        check({tag, "_settling"}, 64'(settling), 64'd0);
        check({tag, "_xfer_err"}, 64'(xfer_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, d0, st0, n;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // VCO only
        busy_len = 40;
        s0 = starts; a0 = vco_acks; st0 = settle_cnt;
        start_vco(1, 32'h00400005, 1'b0);
        wait_quiet(300, "vco_only");
        check("vco_only_starts", 64'(starts - s0), 64'd1);
        check("vco_only_acks", 64'(vco_acks - a0), 64'd1);
        check("vco_only_no_settle", 64'(settle_cnt - st0), 64'd0);

        // DAC only
        dac_sclk_divider = 32'd4;
        s0 = starts; d0 = dac_acks;
        start_dac(1, 32'h18100000);
        wait_quiet(300, "dac_only");
        check("dac_only_starts", 64'(starts - s0), 64'd1);
        check("dac_only_acks", 64'(dac_acks - d0), 64'd1);

        // Settle hold-off with DAC waiting
        busy_len = 10;
        start_log.delete();
        st0 = settle_cnt; dac_start_cyc = -1; dac_watch = 1'b1;
        start_vco(1, 32'h00400105, 1'b1);
        start_dac(1, 32'h18200000);
        wait_quiet(600, "settle");
        dac_watch = 1'b0;
        check("settle_starts", 64'(start_log.size()), 64'd2);
        check("settle_vco_first", 64'(start_log[0]), 64'd1);
        check("settle_length", 64'(settle_cnt - st0), 64'(SETTLE));
        check("settle_dac_delay", 64'(dac_start_cyc - last_vco_ack_cyc), 64'(SETTLE + 1));

        // Starvation guard: 8 VCO grants then one DAC grant
        busy_len = 3;
        dac_sclk_divider = 32'd6;
        start_log.delete();
        start_vco(18, 32'h00400200, 1'b0);
        start_dac(3, 32'h18300000);
        wait_quiet(3000, "starve");
        check("starve_count", 64'(start_log.size()), 64'd21);
        for (int i = 0; i < 21; i++) begin
            bit exp_dev;
            exp_dev = !(i == 8 || i == 17 || i == 20);
            check($sformatf("starve_order_%0d", i), 64'(start_log[i]), 64'(exp_dev));
        end

        // Busy timeout: core never drops ready
        check("pre_timeout_err", 64'(xfer_err), 64'd0);
        core_stuck = 1'b1;
        err_cyc = -1; a0 = vco_acks;
        start_vco(1, 32'h00400305, 1'b0);
        wait_quiet(100, "timeout");
        check("timeout_err", 64'(xfer_err), 64'd1);
        check("timeout_ack", 64'(vco_acks - a0), 64'd1);
        check("timeout_err_delay", 64'(err_cyc - start_cyc), 64'(TOUT + 1));
        check("timeout_ack_delay", 64'(last_vco_ack_cyc - start_cyc), 64'(TOUT + 1));
        core_stuck = 1'b0;
        d0 = dac_acks;
        start_dac(1, 32'h18400000);
        wait_quiet(300, "after_timeout");
        check("after_timeout_dac_ack", 64'(dac_acks - d0), 64'd1);
        check("after_timeout_err_sticky", 64'(xfer_err), 64'd1);

        // Reset in WAIT_DONE
        busy_len = 40;
        s0 = starts; a0 = vco_acks;
        start_vco(1, 32'h00400405, 1'b0);
        n = 0;
        while (starts == s0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rst_start_seen", 64'(n < 50), 64'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        vco_req = 1'b0;
        vco_left = 0;
        @(negedge clock);
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_no_ack", 64'(vco_acks - a0), 64'd0);
        start_vco(1, 32'h00400505, 1'b0);
        wait_quiet(300, "post_reset");
        check("post_reset_ack", 64'(vco_acks - a0), 64'd1);
        check("scoreboard_drained", 64'(vco_q.size() + dac_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
